// File: rtl/diff_acc_pkg.sv
// Shared types for the diff_acc packet accumulator.
package diff_acc_pkg;

    typedef enum logic {ACC, HOLD} diff_acc_state_t;

endpackage

// File: rtl/dti_s_if.sv
// Streaming data/valid/ready interface with end-of-transfer marker.
interface dti_s_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] data;
    logic         dvalid;
    logic         dready;
    logic         eot;

    modport producer (output data, output dvalid, output eot, input dready);
    modport consumer (input data, input dvalid, input eot, output dready);
endinterface

// File: rtl/diff_acc_sat_add.sv
// Combinational W-bit adder with optional signed/unsigned clamping; sums at W+1 bits.
module sat_add #(
    parameter int unsigned W        = 8,
    parameter int unsigned SIGNED   = 0,
    parameter int unsigned SATURATE = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);
    localparam logic [W-1:0] SMIN = W'(1) << (W - 1);
    localparam logic [W-1:0] SMAX = ~SMIN;

    logic [W:0] w_wide;

    always_comb begin
        if (SIGNED != 0) begin
            w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};
        end else begin
            w_wide = {1'b0, i_a} + {1'b0, i_b};
        end

        o_sum = w_wide[W-1:0];
        if (SATURATE != 0) begin
            // Signed overflow shows as the two top bits disagreeing; the carry bit gives direction.
            if (SIGNED != 0) begin
                if (w_wide[W] != w_wide[W-1]) begin
                    o_sum = w_wide[W] ? SMIN : SMAX;
                end
            end else if (w_wide[W]) begin
                o_sum = '1;
            end
        end
    end
endmodule

// File: rtl/diff_acc.sv
// Packet accumulator: sums each din packet (closed by eot or MAX_LEN) into one dout word.
module diff_acc
    import diff_acc_pkg::*;
#(
    parameter int unsigned DIN        = 0,
    parameter int unsigned DIN_SIGNED = 0,
    parameter int unsigned DOUT       = 16,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned MAX_LEN    = 0
) (
    input  logic        clk,
    input  logic        rst,
    dti_s_if.consumer   din,
    dti_s_if.producer   dout
);
    localparam int unsigned DW = (DIN >= 1) ? DIN : 1;
    localparam int unsigned CW = (MAX_LEN >= 1) ? $clog2(MAX_LEN + 1) : 1;

    diff_acc_state_t r_state;
    diff_acc_state_t w_next;

    logic [DOUT-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_first;

    logic [DW-1:0]   w_din_data;
    logic [DOUT-1:0] w_ext;
    logic [DOUT-1:0] w_sum;
    logic            w_din_ready;
    logic            w_dout_valid;
    logic [DOUT-1:0] w_dout_data;
    logic            w_in_hs;
    logic            w_out_hs;
    logic            w_cnt_hit;
    logic            w_close;

    assign w_din_data = din.data[DW-1:0];

    // Any DIN-bit value already fits in DOUT bits, so the extra internal bit carries no information.
    assign w_ext = (DIN_SIGNED != 0) ? DOUT'($signed(w_din_data)) : DOUT'(w_din_data);

    sat_add #(
        .W        (DOUT),
        .SIGNED   (DIN_SIGNED),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_ext),
        .o_sum (w_sum)
    );

    assign w_in_hs   = din.dvalid & w_din_ready;
    assign w_out_hs  = w_dout_valid & dout.dready;
    assign w_cnt_hit = (MAX_LEN != 0) && (32'(r_cnt) == MAX_LEN - 1);
    assign w_close   = w_in_hs & (din.eot | w_cnt_hit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACC:     if (w_close)     w_next = HOLD;
            HOLD:    if (dout.dready) w_next = ACC;
            default: w_next = ACC;
        endcase
    end

    always_comb begin
        w_din_ready  = 1'b0;
        w_dout_valid = 1'b0;
        w_dout_data  = '0;
        if (r_state == HOLD) begin
            w_dout_valid = 1'b1;
            w_dout_data  = r_acc;
        end else begin
            w_din_ready  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b1;
        end else if (w_in_hs) begin
            r_acc   <= r_first ? w_ext : w_sum;
            r_cnt   <= r_cnt + 1'b1;
            r_first <= 1'b0;
        end else if (w_out_hs) begin
            r_cnt   <= '0;
            r_first <= 1'b1;
        end
    end

    assign din.dready  = w_din_ready;
    assign dout.dvalid = w_dout_valid;
    assign dout.data   = w_dout_data;
    assign dout.eot    = 1'b0;
endmodule

// File: tb/tb_diff_acc.sv
// Directed bench for diff_acc across four parameter sets sharing one clock and reset.
module tb_diff_acc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] in_data  [4];
    logic       in_valid [4];
    logic       in_eot   [4];
    logic       out_ready[4];
    logic       in_ready [4];
    logic       out_valid[4];
    logic [7:0] out_data [4];

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    // A: unsigned 4->8 saturating; B: signed 5->6 saturating; C: signed 5->6 wrapping; D: unsigned 4->8, MAX_LEN=4
    dti_s_if #(.W(4)) ifa_in ();
    dti_s_if #(.W(8)) ifa_out ();
    dti_s_if #(.W(5)) ifb_in ();
    dti_s_if #(.W(6)) ifb_out ();
    dti_s_if #(.W(5)) ifc_in ();
    dti_s_if #(.W(6)) ifc_out ();
    dti_s_if #(.W(4)) ifd_in ();
    dti_s_if #(.W(8)) ifd_out ();

    diff_acc #(.DIN(4), .DIN_SIGNED(0), .DOUT(8), .SATURATE(1), .MAX_LEN(0)) u_a (
        .clk(clk), .rst(rst), .din(ifa_in), .dout(ifa_out));
    diff_acc #(.DIN(5), .DIN_SIGNED(1), .DOUT(6), .SATURATE(1), .MAX_LEN(0)) u_b (
        .clk(clk), .rst(rst), .din(ifb_in), .dout(ifb_out));
    diff_acc #(.DIN(5), .DIN_SIGNED(1), .DOUT(6), .SATURATE(0), .MAX_LEN(0)) u_c (
        .clk(clk), .rst(rst), .din(ifc_in), .dout(ifc_out));
    diff_acc #(.DIN(4), .DIN_SIGNED(0), .DOUT(8), .SATURATE(1), .MAX_LEN(4)) u_d (
        .clk(clk), .rst(rst), .din(ifd_in), .dout(ifd_out));

    assign ifa_in.data = in_data[0][3:0];
    assign ifb_in.data = in_data[1][4:0];
    assign ifc_in.data = in_data[2][4:0];
    assign ifd_in.data = in_data[3][3:0];
    assign ifa_in.dvalid = in_valid[0];
    assign ifb_in.dvalid = in_valid[1];
    assign ifc_in.dvalid = in_valid[2];
    assign ifd_in.dvalid = in_valid[3];
    assign ifa_in.eot = in_eot[0];
    assign ifb_in.eot = in_eot[1];
    assign ifc_in.eot = in_eot[2];
    assign ifd_in.eot = in_eot[3];
    assign ifa_out.dready = out_ready[0];
    assign ifb_out.dready = out_ready[1];
    assign ifc_out.dready = out_ready[2];
    assign ifd_out.dready = out_ready[3];

    assign in_ready[0] = ifa_in.dready;
    assign in_ready[1] = ifb_in.dready;
    assign in_ready[2] = ifc_in.dready;
    assign in_ready[3] = ifd_in.dready;
    assign out_valid[0] = ifa_out.dvalid;
    assign out_valid[1] = ifb_out.dvalid;
    assign out_valid[2] = ifc_out.dvalid;
    assign out_valid[3] = ifd_out.dvalid;
    assign out_data[0] = ifa_out.data;
    assign out_data[1] = {2'b00, ifb_out.data};
    assign out_data[2] = {2'b00, ifc_out.data};
    assign out_data[3] = ifd_out.data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and returns just after the edge on which it was accepted.
    task automatic send(input int k, input logic [7:0] d, input logic e);
        int unsigned n = 0;
        in_data[k]  = d;
        in_eot[k]   = e;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("send_timeout", n, 0);
        step();
        in_valid[k] = 1'b0;
        in_eot[k]   = 1'b0;
    endtask

    task automatic result(input int k, input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, out_valid[k], 1);
        chk({tag, "_data"}, out_data[k], exp);
        chk({tag, "_inrdy"}, in_ready[k], 0);
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = '0;
            in_valid[i] = 1'b0;
            in_eot[i] = 1'b0;
            out_ready[i] = 1'b1;
        end
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("rst_inrdy", in_ready[i], 1);
            chk("rst_valid", out_valid[i], 0);
            chk("rst_data", out_data[i], 0);
        end
        rst = 1'b1;
        step();

        // 3+5+7 = 15; result visible the cycle after the eot handshake, din stalls for one cycle
        send(0, 8'd3, 1'b0);
        send(0, 8'd5, 1'b0);
        chk("a_no_early_valid", out_valid[0], 0);
        send(0, 8'd7, 1'b1);
        result(0, "a_sum15", 8'd15);
        step();
        chk("a_post_valid", out_valid[0], 0);
        chk("a_post_inrdy", in_ready[0], 1);
        chk("a_post_data", out_data[0], 0);

        // signed saturate: -16*3 clamps at -32 (0x20)
        send(1, 8'h10, 1'b0);
        send(1, 8'h10, 1'b0);
        send(1, 8'h10, 1'b1);
        result(1, "b_sat_neg", 8'h20);
        step();

        // signed wrap: 45 mod 64 = 0x2D (-19)
        send(2, 8'h0F, 1'b0);
        send(2, 8'h0F, 1'b0);
        send(2, 8'h0F, 1'b1);
        result(2, "c_wrap", 8'h2D);
        step();

        // MAX_LEN=4 without eot: 1+2+3+4 = 10, 5+6+7+8 = 26
        for (int w = 1; w <= 3; w++) send(3, 8'(w), 1'b0);
        chk("d_pre_close", out_valid[3], 0);
        send(3, 8'd4, 1'b0);
        result(3, "d_len_10", 8'd10);
        step();
        for (int w = 5; w <= 8; w++) send(3, 8'(w), 1'b0);
        result(3, "d_len_26", 8'd26);
        step();

        // eot together with count hit closes once; next single-word packet is independent
        for (int w = 0; w < 3; w++) send(3, 8'd1, 1'b0);
        send(3, 8'd1, 1'b1);
        result(3, "d_eot_hit", 8'd4);
        step();
        chk("d_single_close", out_valid[3], 0);
        send(3, 8'd9, 1'b1);
        result(3, "d_single_word", 8'd9);
        step();

        // backpressure: result held stable for 5 cycles, din stalled
        out_ready[0] = 1'b0;
        send(0, 8'd4, 1'b0);
        send(0, 8'd6, 1'b1);
        for (int c = 0; c < 5; c++) begin
            result(0, "a_bp_hold", 8'd10);
            step();
        end
        out_ready[0] = 1'b1;
        step();
        chk("a_bp_release", out_valid[0], 0);
        send(0, 8'd1, 1'b1);
        result(0, "a_bp_fresh", 8'd1);
        step();

        // reset mid-packet drops partial sum
        send(0, 8'd9, 1'b0);
        send(0, 8'd9, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("a_rst_mid_valid", out_valid[0], 0);
        chk("a_rst_mid_inrdy", in_ready[0], 1);
        send(0, 8'd2, 1'b0);
        send(0, 8'd2, 1'b1);
        result(0, "a_after_rst", 8'd4);
        step();

        // reset in HOLD drops pending result
        out_ready[0] = 1'b0;
        send(0, 8'd3, 1'b1);
        result(0, "a_hold_pre_rst", 8'd3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("a_rst_hold_valid", out_valid[0], 0);
        chk("a_rst_hold_data", out_data[0], 0);
        out_ready[0] = 1'b1;
        send(0, 8'd5, 1'b1);
        result(0, "a_after_hold_rst", 8'd5);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/diff_acc.md
# diff_acc

Accumulator stage that consumes the difference stream produced by the `sub` block and reduces each packet to one sum. It sums all words of a packet on its `din` DTI interface and emits a single result word on `dout`, saturating or wrapping per parameter. A packet ends on a word with `din.eot` high, or when a configurable word count is reached. It sits directly downstream of `sub` and accepts `sub`'s widened `TDOUT` output as its input width.

## Interface
- `DIN`, 0: width of `din.data` in bits (must be ≥1)
- `DIN_SIGNED`, 0: 1 = `din.data` is two's complement, 0 = unsigned
- `DOUT`, 16: width of `dout.data`; must be ≥ `DIN`
- `SATURATE`, 1: 1 = clamp the result to the `DOUT` range, 0 = wrap modulo 2^DOUT
- `MAX_LEN`, 0: force packet close after this many words; 0 = unlimited (close only on `eot`)
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  reset, synchronous, active-low
- `din`  dti_s_if.consumer  DIN  input stream (`data`, `dvalid`, `dready`, `eot`)
- `dout`  dti_s_if.producer  DOUT  one result word per packet; `dout.eot` is tied to 0

## Operation
- Input extension: `din.data` is sign-extended when `DIN_SIGNED`, otherwise zero-extended, to the internal width `DOUT+1`. The result is signed iff `DIN_SIGNED`.
- FSM states are `ACC` and `HOLD`. Reset places the FSM in `ACC`.
- **ACC state**
  - `din.dready` = 1 and `dout.dvalid` = 0.
  - On a `din` handshake: `acc <= first ? ext(din.data) : sat_add(acc, ext(din.data))`, then `first <= 0` and `cnt <= cnt+1`.
  - Packet close: the handshake word has `din.eot`=1, or `MAX_LEN`≠0 and `cnt == MAX_LEN-1`. On close the FSM goes to `HOLD`, and `cnt` and `first` are not yet reset.
- **HOLD state**
  - `din.dready` = 0, `dout.dvalid` = 1, `dout.data` = `acc[DOUT-1:0]`.
  - On a `dout` handshake (`dvalid & dready`): go to `ACC`, `first <= 1`, `cnt <= 0`.
- Saturation when `SATURATE`=1:
  - Signed: result clamps to [-2^(DOUT-1), 2^(DOUT-1)-1].
  - Unsigned: result clamps to [0, 2^DOUT-1].
  - The clamp is applied on every add, so the running sum never leaves range.
- `SATURATE`=0: the sum wraps and the internal MSB is discarded.
- A single-word packet (eot on the first word) outputs that word extended.
- `dout.data` is stable while `dout.dvalid`=1 and `dout.dready`=0.
- Reset values: `dout.dvalid`=0, `din.dready` follows state (1 after reset), `acc`=0, `cnt`=0, `first`=1. `dout.data` reads 0 while in `ACC`.
- Reset mid-packet discards the partial sum. Reset in `HOLD` drops the pending result with no output handshake.

## Timing
- Result latency: `dout.dvalid` rises on the cycle after the closing `din` handshake.
- `din.dready` is combinational from state only. It has no combinational path from `dout.dready`.
- Throughput: N-word packet needs N accept cycles plus at least 1 `HOLD` cycle, so at least one bubble on `din` per packet.
- While in `HOLD`, `din` is stalled. An upstream `sub` holds `din0`/`din1` and sees no handshake.
- `eot` and a `MAX_LEN` hit on the same word close the packet once (identical behaviour).
- `cnt` width is `$clog2(MAX_LEN+1)`, minimum 1.

## Structure
- `diff_acc_pkg`: `typedef enum logic {ACC, HOLD} diff_acc_state_t;`
- Sub-module `sat_add`: combinational, parameters `W` and `SIGNED`. It adds two W-bit operands at W+1 internal width and clamps or wraps to W bits per `SATURATE`.
- Top `diff_acc`: FSM, `acc`/`cnt`/`first` registers, extension logic, and `sat_add` instance.

## Test plan
- Unsigned, DIN=4, DOUT=8: packet 3,5,7 (eot on 7) with `dout.dready`=1 → single `dout` word 15, valid one cycle after the eot handshake; `din.dready`=0 for exactly one cycle.
- Signed, DIN=5, DOUT=6, SATURATE=1: -16,-16,-16 eot → -32 (0x20), with no wrap to positive.
- Signed, SATURATE=0, DOUT=6: 15,15,15 eot → 45 wraps to -19 (0x2D).
- MAX_LEN=4, eot never asserted, stream 1..8 → outputs 10 then 26. A word with eot plus count hit produces one close only.
- Backpressure: `dout.dready`=0 for 5 cycles in `HOLD` → `dout.data` stable and `din.dready`=0 throughout. Release → next packet sum starts fresh (`first` reset).
- Reset (`rst`=0 for one cycle) after 2 words of a packet → no output. The next packet 2,2 eot → 4.
